memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Pipeline MEM stage of the 64-bit RISC-V core; sits between the EX/MEM register and the writeback stage.
- Accepts one instruction per handshake and issues at most one data-bus transaction per instruction; blocking, one outstanding access.
- Aligns store data and byte strobes; extracts and sign/zero-extends load data.
- Registers a MEM/WB bundle (valid, instrAddr, instr, wd, isWriteBack, result) for the writeback stage.

Parameters:
- ADDR_W, 64, data address width
- DATA_W, 64, bus/register data width (fixed at 64; strobe is DATA_W/8)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- in_valid  in  1  EX/MEM entry valid
- in_ready  out  1  stage can accept; upstream holds its entry while 0
- in_instrAddr  in  64  PC
- in_instr  in  32  instruction word
- in_aluOut  in  64  ALU result / effective address
- in_wd  in  5  destination register
- in_isWriteBack  in  1  writes rd
- in_memRead  in  1  load
- in_memWrite  in  1  store; never asserted together with in_memRead
- in_memSize  in  2  0=B 1=H 2=W 3=D
- in_memUnsigned  in  1  zero-extend load
- in_storeData  in  64  rs2 value, LSB-aligned
- dreq_valid  out  1  bus request
- dreq_write  out  1  1=store
- dreq_addr  out  64  byte address (unaligned within the doubleword)
- dreq_size  out  2  copy of memSize
- dreq_strobe  out  8  byte enables (stores; 0 for loads)
- dreq_data  out  64  lane-shifted store data
- dresp_ok  in  1  access complete this cycle
- dresp_data  in  64  full aligned doubleword read
- out_valid  out  1  MEM/WB entry valid
- out_instrAddr  out  64
- out_instr  out  32
- out_wd  out  5
- out_isWriteBack  out  1
- out_result  out  64  load data or in_aluOut
- out_misalign  out  1  misaligned access flagged

Behaviour:
- Reset (rst=0, async): state=IDLE; dreq_valid=0 immediately; all other outputs and captured registers 0; an in-flight access is abandoned and its late dresp_ok is ignored, since IDLE does not sample dresp.
- FSM states: IDLE and WAIT. in_ready = (state==IDLE).
- IDLE, accept (in_valid=1):
  - Non-memory op: next cycle out_valid=1 with the fields passed through and out_result=in_aluOut. Latency 1.
  - Misaligned memory op: address not size-aligned (H: a[0]; W: a[1:0]; D: a[2:0] nonzero). Next cycle out_valid=1, out_misalign=1, out_isWriteBack=0, out_result=in_aluOut. No bus request; stay IDLE.
  - Aligned memory op: capture all fields; next state WAIT.
- IDLE, no accept: out_valid=0.
- WAIT:
  - dreq_valid=1; request fields stable until dresp_ok.
  - dreq_strobe = sizemask << a[2:0] (B=0x01, H=0x03, W=0x0F, D=0xFF).
  - dreq_data = storeData << (8*a[2:0]).
  - out_valid=0 while waiting.
  - On dresp_ok=1 (sampled every WAIT cycle, including the first): next cycle out_valid=1 and state=IDLE.
  - Load result: shift dresp_data right by 8*a[2:0], truncate to size, then sign-extend, or zero-extend if in_memUnsigned; D is unchanged.
  - Store result: out_result=aluOut; out_isWriteBack from the captured value.
- Load/store latency: accept at T, dreq_valid from T+1, dresp_ok at cycle T+k (k≥1), out_valid at T+k+1. Throughput is one access per k+1 cycles.
- Back-to-back: a new entry may be accepted in the cycle out_valid is high, because state is IDLE then.
- out_valid is a one-cycle pulse per accepted instruction; there is no downstream backpressure.
- out_misalign=0 for all non-misaligned results.

Test Plan:
- Reset with rst=0 mid-WAIT -> dreq_valid drops the same cycle; out_valid=0; after release in_ready=1; a stray dresp_ok produces no output.
- ALU op aluOut=0x1234, wd=5, isWriteBack=1 -> one cycle later out_valid=1, out_result=0x1234, out_wd=5; in_ready stays 1.
- LB addr=0x1003, dresp_data=0x0000_0000_8000_0000 with dresp_ok 3 cycles after request -> strobe=0; out_result=0xFFFF_FFFF_FFFF_FF80; out_valid 4 cycles after accept; LBU on the same data -> 0x80.
- SH addr=0x1006, storeData=0xABCD -> dreq_strobe=0xC0, dreq_data=0xABCD_0000_0000_0000, dreq_write=1; in_ready=0 until dresp_ok.
- LW addr=0x1002 -> no dreq_valid; next cycle out_misalign=1, out_isWriteBack=0.
- LD then ADD issued back-to-back with dresp_ok in the first WAIT cycle -> the ADD is accepted in the LD's out_valid cycle; out_valid pulses on 2 consecutive cycles with the correct results.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the 64-bit RISC-V pipeline.
//
// Accepts one EX/MEM entry per handshake. Non-memory and misaligned
// entries are passed to writeback after one cycle. Aligned loads and
// stores issue one blocking data-bus transaction each. Store data and
// byte strobes are shifted into their byte lanes. Load data is taken
// from the returned doubleword and then sign- or zero-extended.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   in_*                 EX/MEM entry; in_ready is high while idle
//   dreq_*               data-bus request, held stable until dresp_ok
//   dresp_ok, dresp_data bus completion and aligned read doubleword
//   out_*                registered MEM/WB bundle; out_valid is a 1-cycle pulse
module memory_stage #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [63:0]           in_instrAddr,
    input  logic [31:0]           in_instr,
    input  logic [DATA_W-1:0]     in_aluOut,
    input  logic [4:0]            in_wd,
    input  logic                  in_isWriteBack,
    input  logic                  in_memRead,
    input  logic                  in_memWrite,
    input  logic [1:0]            in_memSize,
    input  logic                  in_memUnsigned,
    input  logic [DATA_W-1:0]     in_storeData,
    output logic                  dreq_valid,
    output logic                  dreq_write,
    output logic [ADDR_W-1:0]     dreq_addr,
    output logic [1:0]            dreq_size,
    output logic [DATA_W/8-1:0]   dreq_strobe,
    output logic [DATA_W-1:0]     dreq_data,
    input  logic                  dresp_ok,
    input  logic [DATA_W-1:0]     dresp_data,
    output logic                  out_valid,
    output logic [63:0]           out_instrAddr,
    output logic [31:0]           out_instr,
    output logic [4:0]            out_wd,
    output logic                  out_isWriteBack,
    output logic [DATA_W-1:0]     out_result,
    output logic                  out_misalign
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state_q, state_d;

    // Entry captured at accept for the duration of a bus access
    logic [63:0]         instr_addr_q, instr_addr_d;
    logic [31:0]         instr_q, instr_d;
    logic [DATA_W-1:0]   alu_out_q, alu_out_d;
    logic [4:0]          wd_q, wd_d;
    logic                wb_q, wb_d;
    logic                mem_write_q, mem_write_d;
    logic [1:0]          mem_size_q, mem_size_d;
    logic                mem_unsigned_q, mem_unsigned_d;
    logic [DATA_W-1:0]   store_data_q, store_data_d;

    // MEM/WB bundle
    logic                out_valid_q, out_valid_d;
    logic [63:0]         out_instr_addr_q, out_instr_addr_d;
    logic [31:0]         out_instr_q, out_instr_d;
    logic [4:0]          out_wd_q, out_wd_d;
    logic                out_wb_q, out_wb_d;
    logic [DATA_W-1:0]   out_result_q, out_result_d;
    logic                out_misalign_q, out_misalign_d;

    logic                in_is_mem;
    logic                in_misaligned;
    logic [DATA_W-1:0]   load_shifted;
    logic [DATA_W-1:0]   load_value;
    logic [7:0]          size_mask;

    // An access is misaligned when the low address bits below its size are nonzero
    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = |off[1:0];
            2'd3:    misaligned = |off;
            default: misaligned = 1'b0;
        endcase
    endfunction

    assign in_is_mem     = in_memRead | in_memWrite;
    assign in_misaligned = misaligned(in_aluOut[2:0], in_memSize);

    // Load extraction: bring the addressed byte lane down to bit 0, then extend
    always_comb begin
        load_shifted = dresp_data >> {alu_out_q[2:0], 3'b000};
        case (mem_size_q)
            2'd0: load_value = mem_unsigned_q ? {56'd0, load_shifted[7:0]}
                                              : {{56{load_shifted[7]}}, load_shifted[7:0]};
            2'd1: load_value = mem_unsigned_q ? {48'd0, load_shifted[15:0]}
                                              : {{48{load_shifted[15]}}, load_shifted[15:0]};
            2'd2: load_value = mem_unsigned_q ? {32'd0, load_shifted[31:0]}
                                              : {{32{load_shifted[31]}}, load_shifted[31:0]};
            default: load_value = load_shifted;
        endcase
    end

    always_comb begin
        case (mem_size_q)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Bus request is driven purely from the captured entry while waiting
    assign in_ready    = (state_q == S_IDLE);
    assign dreq_valid  = (state_q == S_WAIT);
    assign dreq_write  = dreq_valid & mem_write_q;
    assign dreq_addr   = dreq_valid ? alu_out_q[ADDR_W-1:0] : '0;
    assign dreq_size   = dreq_valid ? mem_size_q : 2'd0;
    assign dreq_strobe = dreq_write ? (size_mask << alu_out_q[2:0]) : 8'h00;
    assign dreq_data   = dreq_valid ? (store_data_q << {alu_out_q[2:0], 3'b000}) : '0;

    // Next-state and MEM/WB bundle
    always_comb begin
        state_d          = state_q;
        instr_addr_d     = instr_addr_q;
        instr_d          = instr_q;
        alu_out_d        = alu_out_q;
        wd_d             = wd_q;
        wb_d             = wb_q;
        mem_write_d      = mem_write_q;
        mem_size_d       = mem_size_q;
        mem_unsigned_d   = mem_unsigned_q;
        store_data_d     = store_data_q;
        out_valid_d      = 1'b0;
        out_instr_addr_d = out_instr_addr_q;
        out_instr_d      = out_instr_q;
        out_wd_d         = out_wd_q;
        out_wb_d         = out_wb_q;
        out_result_d     = out_result_q;
        out_misalign_d   = out_misalign_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_is_mem && !in_misaligned) begin
                        instr_addr_d   = in_instrAddr;
                        instr_d        = in_instr;
                        alu_out_d      = in_aluOut;
                        wd_d           = in_wd;
                        wb_d           = in_isWriteBack;
                        mem_write_d    = in_memWrite;
                        mem_size_d     = in_memSize;
                        mem_unsigned_d = in_memUnsigned;
                        store_data_d   = in_storeData;
                        state_d        = S_WAIT;
                    end else begin
                        // Misaligned accesses complete immediately with no register write
                        out_valid_d      = 1'b1;
                        out_instr_addr_d = in_instrAddr;
                        out_instr_d      = in_instr;
                        out_wd_d         = in_wd;
                        out_wb_d         = in_isWriteBack & ~in_is_mem;
                        out_result_d     = in_aluOut;
                        out_misalign_d   = in_is_mem;
                    end
                end
            end
            S_WAIT: begin
                if (dresp_ok) begin
                    state_d          = S_IDLE;
                    out_valid_d      = 1'b1;
                    out_instr_addr_d = instr_addr_q;
                    out_instr_d      = instr_q;
                    out_wd_d         = wd_q;
                    out_wb_d         = wb_q;
                    out_result_d     = mem_write_q ? alu_out_q : load_value;
                    out_misalign_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            instr_addr_q     <= '0;
            instr_q          <= '0;
            alu_out_q        <= '0;
            wd_q             <= '0;
            wb_q             <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_size_q       <= '0;
            mem_unsigned_q   <= 1'b0;
            store_data_q     <= '0;
            out_valid_q      <= 1'b0;
            out_instr_addr_q <= '0;
            out_instr_q      <= '0;
            out_wd_q         <= '0;
            out_wb_q         <= 1'b0;
            out_result_q     <= '0;
            out_misalign_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            instr_addr_q     <= instr_addr_d;
            instr_q          <= instr_d;
            alu_out_q        <= alu_out_d;
            wd_q             <= wd_d;
            wb_q             <= wb_d;
            mem_write_q      <= mem_write_d;
            mem_size_q       <= mem_size_d;
            mem_unsigned_q   <= mem_unsigned_d;
            store_data_q     <= store_data_d;
            out_valid_q      <= out_valid_d;
            out_instr_addr_q <= out_instr_addr_d;
            out_instr_q      <= out_instr_d;
            out_wd_q         <= out_wd_d;
            out_wb_q         <= out_wb_d;
            out_result_q     <= out_result_d;
            out_misalign_q   <= out_misalign_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_instrAddr   = out_instr_addr_q;
    assign out_instr       = out_instr_q;
    assign out_wd          = out_wd_q;
    assign out_isWriteBack = out_wb_q;
    assign out_result      = out_result_q;
    assign out_misalign    = out_misalign_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage.
// A driver issues directed and random entries and pushes the expected
// MEM/WB bundle and bus request; a monitor running 1 time unit after each
// rising edge models the handshake, plays the bus slave and pops/compares.
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_instrAddr;
    logic [31:0] in_instr;
    logic [63:0] in_aluOut;
    logic [4:0]  in_wd;
    logic        in_isWriteBack;
    logic        in_memRead;
    logic        in_memWrite;
    logic [1:0]  in_memSize;
    logic        in_memUnsigned;
    logic [63:0] in_storeData;
    logic        dreq_valid;
    logic        dreq_write;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_ok;
    logic [63:0] dresp_data;
    logic        out_valid;
    logic [63:0] out_instrAddr;
    logic [31:0] out_instr;
    logic [4:0]  out_wd;
    logic        out_isWriteBack;
    logic [63:0] out_result;
    logic        out_misalign;

    memory_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instrAddr(in_instrAddr), .in_instr(in_instr), .in_aluOut(in_aluOut),
        .in_wd(in_wd), .in_isWriteBack(in_isWriteBack),
        .in_memRead(in_memRead), .in_memWrite(in_memWrite),
        .in_memSize(in_memSize), .in_memUnsigned(in_memUnsigned),
        .in_storeData(in_storeData),
        .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_ok(dresp_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_instrAddr(out_instrAddr), .out_instr(out_instr),
        .out_wd(out_wd), .out_isWriteBack(out_isWriteBack),
        .out_result(out_result), .out_misalign(out_misalign)
    );

    typedef struct {
        logic [63:0] instr_addr;
        logic [31:0] instr;
        logic [4:0]  wd;
        logic        wb;
        logic [63:0] result;
        logic        misalign;
    } exp_t;

    typedef struct {
        logic        write;
        logic [63:0] addr;
        logic [1:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [63:0] mem [8];
    logic [63:0] pc;

    int  n_checks;
    int  n_fail;
    bit  model_busy;
    bit  resp_en;
    bit  resp_active;
    int  resp_wait;
    int  fixed_delay;
    req_t cur_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference rules, expressed as byte-lane arithmetic
    function automatic int nbytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic bit is_mis(input logic [63:0] addr, input logic [1:0] size);
        return (int'(addr[2:0]) % nbytes(size)) != 0;
    endfunction

    function automatic logic [63:0] load_model(input logic [63:0] word, input int off,
                                               input logic [1:0] size, input bit uns);
        logic [63:0] v;
        int n;
        n = nbytes(size);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
        if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    function automatic logic [7:0] strobe_model(input int off, input logic [1:0] size);
        logic [7:0] s;
        s = '0;
        for (int i = off; i < off + nbytes(size); i++) s[i] = 1'b1;
        return s;
    endfunction

    // kind: 0 = ALU op, 1 = load, 2 = store
    task automatic apply_stimulus(input int kind, input logic [63:0] addr, input logic [1:0] size,
                                  input bit uns, input logic [63:0] sd, input logic [4:0] wd,
                                  input bit wb, input bit use_want, input logic [63:0] want);
        exp_t e;
        req_t r;
        bit   mis;
        bit   mem_op;
        int   waited;
        pc = pc + 64'd4;
        in_valid       = 1'b1;
        in_instrAddr   = pc;
        in_instr       = $urandom;
        in_aluOut      = addr;
        in_wd          = wd;
        in_isWriteBack = wb;
        in_memRead     = (kind == 1);
        in_memWrite    = (kind == 2);
        in_memSize     = size;
        in_memUnsigned = uns;
        in_storeData   = sd;
        mem_op = (kind != 0);
        mis    = mem_op && is_mis(addr, size);
        e.instr_addr = pc;
        e.instr      = in_instr;
        e.wd         = wd;
        e.wb         = mis ? 1'b0 : wb;
        e.misalign   = mis;
        if (kind == 1 && !mis) e.result = load_model(mem[addr[5:3]], int'(addr[2:0]), size, uns);
        else                   e.result = addr;
        if (use_want) e.result = want;
        waited = 0;
        while (!in_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1 within 64 cycles");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        if (mem_op && !mis) begin
            r.write  = (kind == 2);
            r.addr   = addr;
            r.size   = size;
            r.strobe = (kind == 2) ? strobe_model(int'(addr[2:0]), size) : 8'h00;
            r.data   = sd << (8 * int'(addr[2:0]));
            req_q.push_back(r);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor, handshake model and bus slave
    initial begin
        exp_t e;
        bit   fired;
        model_busy  = 1'b0;
        resp_active = 1'b0;
        resp_wait   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                model_busy  = 1'b0;
                resp_active = 1'b0;
            end else begin
                // What the edge just did, judged from the inputs held across it
                fired = 1'b0;
                if (model_busy) begin
                    if (dresp_ok) begin
                        model_busy = 1'b0;
                        fired      = 1'b1;
                    end
                end else if (in_valid) begin
                    if ((in_memRead || in_memWrite) && !is_mis(in_aluOut, in_memSize))
                        model_busy = 1'b1;
                    else
                        fired = 1'b1;
                end
                check_output("out_valid_timing", 64'(out_valid), 64'(fired));
                check_output("in_ready", 64'(in_ready), 64'(!model_busy));
                check_output("dreq_valid", 64'(dreq_valid), 64'(model_busy));

                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_output: got out_valid=1, expected no pending entry");
                    end else begin
                        e = exp_q.pop_front();
                        check_output("out_instrAddr", out_instrAddr, e.instr_addr);
                        check_output("out_instr", 64'(out_instr), 64'(e.instr));
                        check_output("out_wd", 64'(out_wd), 64'(e.wd));
                        check_output("out_isWriteBack", 64'(out_isWriteBack), 64'(e.wb));
                        check_output("out_result", out_result, e.result);
                        check_output("out_misalign", 64'(out_misalign), 64'(e.misalign));
                    end
                end

                if (resp_en) begin
                    dresp_ok   = 1'b0;
                    dresp_data = {$urandom, $urandom};
                    if (model_busy) begin
                        if (!resp_active) begin
                            if (req_q.size() == 0) begin
                                n_checks++;
                                n_fail++;
                                $display("[TB] FAIL unexpected_request: got dreq_valid=1, expected no request");
                                cur_req = '{1'b0, 64'd0, 2'd0, 8'd0, 64'd0};
                            end else begin
                                cur_req = req_q.pop_front();
                            end
                            resp_active = 1'b1;
                            resp_wait   = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
                        end
                        check_output("dreq_write", 64'(dreq_write), 64'(cur_req.write));
                        check_output("dreq_addr", dreq_addr, cur_req.addr);
                        check_output("dreq_size", 64'(dreq_size), 64'(cur_req.size));
                        check_output("dreq_strobe", 64'(dreq_strobe), 64'(cur_req.strobe));
                        if (cur_req.write) check_output("dreq_data", dreq_data, cur_req.data);
                        if (resp_wait == 0) begin
                            dresp_ok    = 1'b1;
                            dresp_data  = mem[cur_req.addr[5:3]];
                            resp_active = 1'b0;
                        end else begin
                            resp_wait--;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int          kind;
        logic [63:0] a;
        int          waited;
        n_checks = 0;
        n_fail   = 0;
        pc       = 64'h8000_0000;
        resp_en  = 1'b1;
        fixed_delay = -1;
        rst = 1'b0;
        in_valid = 1'b0; in_instrAddr = '0; in_instr = '0; in_aluOut = '0; in_wd = '0;
        in_isWriteBack = 1'b0; in_memRead = 1'b0; in_memWrite = 1'b0; in_memSize = '0;
        in_memUnsigned = 1'b0; in_storeData = '0;
        dresp_ok = 1'b0; dresp_data = '0;
        for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
        mem[0] = 64'h0000_0000_8000_0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_out_valid", 64'(out_valid), 64'd0);
        check_output("reset_in_ready", 64'(in_ready), 64'd1);
        check_output("reset_dreq_valid", 64'(dreq_valid), 64'd0);
        check_output("reset_out_result", out_result, 64'd0);
        check_output("reset_out_misalign", 64'(out_misalign), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] directed: ALU pass-through");
        apply_stimulus(0, 64'h1234, 2'd0, 1'b0, 64'd0, 5'd5, 1'b1, 1'b1, 64'h1234);

        $display("[TB] directed: LB / LBU with response on third wait cycle");
        fixed_delay = 2;
        apply_stimulus(1, 64'h1003, 2'd0, 1'b0, 64'd0, 5'd6, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
        apply_stimulus(1, 64'h1003, 2'd0, 1'b1, 64'd0, 5'd7, 1'b1, 1'b1, 64'h80);

        $display("[TB] directed: SH lane placement");
        apply_stimulus(2, 64'h1006, 2'd1, 1'b0, 64'hABCD, 5'd0, 1'b0, 1'b1, 64'h1006);

        $display("[TB] directed: misaligned LW");
        apply_stimulus(1, 64'h1002, 2'd2, 1'b0, 64'd0, 5'd9, 1'b1, 1'b1, 64'h1002);

        $display("[TB] directed: LD then ADD back-to-back");
        fixed_delay = 0;
        apply_stimulus(1, 64'h1008, 2'd3, 1'b0, 64'd0, 5'd10, 1'b1, 1'b0, 64'd0);
        apply_stimulus(0, 64'h5555, 2'd0, 1'b0, 64'd0, 5'd11, 1'b1, 1'b1, 64'h5555);
        repeat (3) @(negedge clk);

        $display("[TB] directed: reset during a pending access");
        resp_en = 1'b0;
        apply_stimulus(1, 64'h2010, 2'd3, 1'b0, 64'd0, 5'd12, 1'b1, 1'b0, 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_output("midreset_dreq_valid", 64'(dreq_valid), 64'd0);
        check_output("midreset_out_valid", 64'(out_valid), 64'd0);
        check_output("midreset_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        req_q.delete();
        @(negedge clk);
        rst = 1'b1;
        dresp_ok = 1'b1;
        dresp_data = {$urandom, $urandom};
        @(negedge clk);
        dresp_ok = 1'b0;
        repeat (2) @(negedge clk);
        resp_en = 1'b1;

        $display("[TB] random traffic");
        fixed_delay = -1;
        for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
        for (int n = 0; n < 100; n++) begin
            kind = $urandom_range(0, 2);
            a    = {32'h0, $urandom};
            apply_stimulus(kind, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                           1'($urandom_range(0, 1)), 1'b0, 64'd0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        waited = 0;
        while ((exp_q.size() != 0 || model_busy) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_output("drain_pending", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
